zxunouart_fifo: RTL and testbench

Buffered, parametrised ZXUNO UART register interface. It wraps the existing bit-level `uart` core with independent TX and RX FIFOs, and adds a sticky RX-overflow flag and FIFO-level-driven RTS flow control. It sits on the ZXUNO register bus at `UARTDATA`/`UARTSTAT`, where it replaces the unbuffered single-byte interface while keeping status bits 7:6 software-compatible.

---
 rtl/zxunouart_fifo_pkg.sv | 34 +++
 rtl/uart.sv | 115 +++++++++++
 rtl/zxuno_sync_fifo.sv | 69 ++++++
 rtl/zxunouart_fifo.sv | 203 ++++++++++++++++++++
 tb/tb_zxunouart_fifo.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/zxunouart_fifo_pkg.sv
// zxunouart_fifo_pkg: shared constants and types for the buffered ZXUNO UART.
//   - ZXUNO register addresses for the data and status ports
//   - status bit positions (software-visible, bits 7:6 as on the old interface)
//   - TX drain state encoding
//   - helper that packs the status byte
package zxunouart_fifo_pkg;

  localparam logic [7:0] UARTDATA = 8'hC6;
  localparam logic [7:0] UARTSTAT = 8'hC7;

  localparam int UST_RXAVAIL = 7;
  localparam int UST_TXFULL  = 6;
  localparam int UST_RXOVF   = 5;
  localparam int UST_TXIDLE  = 4;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_WAIT  = 2'd2
  } tx_state_e;

  // Assemble the UARTSTAT byte; unused low bits read as zero.
  function automatic logic [7:0] pack_status(input logic rx_avail, input logic tx_full,
                                             input logic rx_ovf, input logic tx_idle);
    logic [7:0] s;
    s = 8'h00;
    s[UST_RXAVAIL] = rx_avail;
    s[UST_TXFULL]  = tx_full;
    s[UST_RXOVF]   = rx_ovf;
    s[UST_TXIDLE]  = tx_idle;
    return s;
  endfunction

endpackage

// File: rtl/uart.sv
// uart: bit-level 8N1 UART core (no reset; every register powers up at zero,
// and the encodings are chosen so that all-zero means "line idle").
// Ports:
//   clk       system clock
//   txdata    byte to send, sampled when txbegin is seen while idle
//   txbegin   start a frame (ignored while busy)
//   txbusy    frame in progress, high from the cycle after txbegin through the stop bit
//   rxdata    last received byte
//   rxrecv    byte available, held until data_read
//   data_read acknowledge; clears rxrecv (wins over a completing frame)
//   rx        serial input
//   tx        serial output, idles high
module uart #(
  parameter int CLK  = 28000000,
  parameter int BAUD = 115200
) (
  input  logic       clk,
  input  logic [7:0] txdata,
  input  logic       txbegin,
  output logic       txbusy,
  output logic [7:0] rxdata,
  output logic       rxrecv,
  input  logic       data_read,
  input  logic       rx,
  output logic       tx
);

  localparam int DIV = CLK / BAUD;

  logic [15:0] tx_div_r;
  logic [3:0]  tx_bit_r;
  logic [8:0]  tx_sh_r;
  logic        tx_busy_r;
  logic        tx_low_r;   // line driven low; zero means idle-high

  logic        rx_low1_r;  // synchroniser holds the inverted line so zero is idle
  logic        rx_low2_r;
  logic        rx_act_r;
  logic [15:0] rx_div_r;
  logic [3:0]  rx_bit_r;
  logic [7:0]  rx_sh_r;
  logic [7:0]  rxdata_r;
  logic        rxrecv_r;

  assign txbusy = tx_busy_r;
  assign tx     = ~tx_low_r;
  assign rxdata = rxdata_r;
  assign rxrecv = rxrecv_r;

  // Transmitter: start bit, 8 data bits LSB first, stop bit; one bit per DIV clocks.
  always_ff @(posedge clk) begin
    if (!tx_busy_r) begin
      if (txbegin) begin
        tx_busy_r <= 1'b1;
        tx_sh_r   <= {1'b1, txdata};
        tx_low_r  <= 1'b1;
        tx_div_r  <= 16'd0;
        tx_bit_r  <= 4'd0;
      end
    end else if (tx_div_r == 16'(DIV - 1)) begin
      tx_div_r <= 16'd0;
      if (tx_bit_r == 4'd9) begin
        tx_busy_r <= 1'b0;
        tx_low_r  <= 1'b0;
      end else begin
        tx_low_r <= ~tx_sh_r[0];
        tx_sh_r  <= {1'b1, tx_sh_r[8:1]};
        tx_bit_r <= tx_bit_r + 4'd1;
      end
    end else begin
      tx_div_r <= tx_div_r + 16'd1;
    end
  end

  // Two-flop synchroniser for the serial input.
  always_ff @(posedge clk) begin
    rx_low1_r <= ~rx;
    rx_low2_r <= rx_low1_r;
  end

  // Receiver: find the start edge, then sample each bit at its centre.
  always_ff @(posedge clk) begin
    if (!rx_act_r) begin
      if (rx_low2_r) begin
        rx_act_r <= 1'b1;
        rx_div_r <= 16'(DIV / 2);
        rx_bit_r <= 4'd0;
      end
    end else if (rx_div_r == 16'd0) begin
      rx_div_r <= 16'(DIV - 1);
      if (rx_bit_r == 4'd0) begin
        if (!rx_low2_r) begin
          rx_act_r <= 1'b0;   // glitch, not a real start bit
        end else begin
          rx_bit_r <= 4'd1;
        end
      end else if (rx_bit_r == 4'd9) begin
        rx_act_r <= 1'b0;
        if (!rx_low2_r) begin
          rxdata_r <= rx_sh_r;
          rxrecv_r <= 1'b1;
        end
      end else begin
        rx_sh_r  <= {~rx_low2_r, rx_sh_r[7:1]};
        rx_bit_r <= rx_bit_r + 4'd1;
      end
    end else begin
      rx_div_r <= rx_div_r - 16'd1;
    end
    if (data_read) begin
      rxrecv_r <= 1'b0;
    end
  end

endmodule

// File: rtl/zxuno_sync_fifo.sv
// zxuno_sync_fifo: single-clock show-ahead FIFO.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (empties the FIFO)
//   push/wdata  write request and data; dropped when full unless a pop happens too
//   pop         read request; ignored when empty
//   rdata       current head (valid only when not empty)
//   count       occupancy, 0..DEPTH
//   full/empty  occupancy flags
module zxuno_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             pop_ok_s;
  logic             push_ok_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == (AW+1)'(0));
  assign count     = count_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign pop_ok_s  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO may still accept.
  assign push_ok_s = push & (~full | pop_ok_s);

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW+1)'(0);
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/zxunouart_fifo.sv
// zxunouart_fifo: buffered ZXUNO UART register interface.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   zxuno_addr         register address (UARTDATA / UARTSTAT)
//   zxuno_regrd/regwr  level read/write strobes, may last several cycles
//   din                write data
//   dout, oe           combinational read data and its valid flag
//   uart_tx, uart_rx   serial line
//   uart_rts           active-low RTS, high once the RX FIFO reaches RTS_LEVEL
module zxunouart_fifo
  import zxunouart_fifo_pkg::*;
#(
  parameter int CLK       = 28000000,
  parameter int TXDEPTH   = 16,
  parameter int RXDEPTH   = 16,
  parameter int RTS_LEVEL = RXDEPTH - 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] zxuno_addr,
  input  logic       zxuno_regrd,
  input  logic       zxuno_regwr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       oe,
  output logic       uart_tx,
  input  logic       uart_rx,
  output logic       uart_rts
);

  localparam int TXCW = $clog2(TXDEPTH) + 1;
  localparam int RXCW = $clog2(RXDEPTH) + 1;

  logic            rd_data_s, rd_stat_s, wr_data_s;
  logic            rd_data_d_r, rd_stat_d_r, wr_data_d_r, rxrecv_d_r;
  logic            data_read_r;
  logic            txbegin_r;
  logic            rx_ovf_r;
  logic            uart_rts_r;
  tx_state_e       state_r, state_nx_s;

  logic            tx_push_s, tx_pop_s, tx_full_s, tx_empty_s;
  logic [7:0]      tx_head_s;
  logic [TXCW-1:0] tx_count_s;
  logic            rx_push_s, rx_pop_s, rx_full_s, rx_empty_s;
  logic [7:0]      rx_head_s;
  logic [RXCW-1:0] rx_count_s;
  logic            rx_ovf_set_s, stat_clr_s, tx_idle_s;

  logic            txbusy_s, rxrecv_s;
  logic [7:0]      rxdata_s;

  assign rd_data_s = zxuno_regrd & (zxuno_addr == UARTDATA);
  assign rd_stat_s = zxuno_regrd & (zxuno_addr == UARTSTAT);
  assign wr_data_s = zxuno_regwr & (zxuno_addr == UARTDATA);

  // One push on the first cycle of a write, one pop/clear on the cycle after a read ends.
  assign tx_push_s    = wr_data_s & ~wr_data_d_r;
  assign rx_pop_s     = rd_data_d_r & ~rd_data_s;
  assign stat_clr_s   = rd_stat_d_r & ~rd_stat_s;
  assign rx_push_s    = rxrecv_s & ~rxrecv_d_r;
  // A full FIFO is never empty, so any pop this cycle makes room.
  assign rx_ovf_set_s = rx_push_s & rx_full_s & ~rx_pop_s;
  assign tx_idle_s    = tx_empty_s & ~txbusy_s;
  assign uart_rts     = uart_rts_r;

  zxuno_sync_fifo #(.WIDTH(8), .DEPTH(TXDEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push_s),
    .wdata (din),
    .pop   (tx_pop_s),
    .rdata (tx_head_s),
    .count (tx_count_s),
    .full  (tx_full_s),
    .empty (tx_empty_s)
  );

  zxuno_sync_fifo #(.WIDTH(8), .DEPTH(RXDEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_push_s),
    .wdata (rxdata_s),
    .pop   (rx_pop_s),
    .rdata (rx_head_s),
    .count (rx_count_s),
    .full  (rx_full_s),
    .empty (rx_empty_s)
  );

  uart #(.CLK(CLK)) u_uart (
    .clk       (clk),
    .txdata    (tx_head_s),
    .txbegin   (txbegin_r),
    .txbusy    (txbusy_s),
    .rxdata    (rxdata_s),
    .rxrecv    (rxrecv_s),
    .data_read (data_read_r),
    .rx        (uart_rx),
    .tx        (uart_tx)
  );

  // Edge-detect history for bus strobes and the core's receive flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_d_r <= 1'b0;
      rd_stat_d_r <= 1'b0;
      wr_data_d_r <= 1'b0;
      rxrecv_d_r  <= 1'b0;
      // Held high in reset so a byte finishing during reset is acknowledged and dropped.
      data_read_r <= 1'b1;
    end else begin
      rd_data_d_r <= rd_data_s;
      rd_stat_d_r <= rd_stat_s;
      wr_data_d_r <= wr_data_s;
      rxrecv_d_r  <= rxrecv_s;
      data_read_r <= rx_push_s;
    end
  end

  // TX drain next state; the head is popped once the core has taken it.
  always_comb begin
    state_nx_s = state_r;
    tx_pop_s   = 1'b0;
    case (state_r)
      TX_IDLE: begin
        if ((tx_count_s != TXCW'(0)) && !txbusy_s) begin
          state_nx_s = TX_START;
        end else begin
          state_nx_s = TX_IDLE;
        end
      end
      TX_START: begin
        if (txbusy_s) begin
          state_nx_s = TX_WAIT;
          tx_pop_s   = 1'b1;
        end else begin
          state_nx_s = TX_START;
        end
      end
      TX_WAIT: begin
        if (!txbusy_s) begin
          state_nx_s = TX_IDLE;
        end else begin
          state_nx_s = TX_WAIT;
        end
      end
      default: begin
        state_nx_s = TX_IDLE;
      end
    endcase
  end

  // TX state register; txbegin is registered from the next state so it is high throughout START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= TX_IDLE;
      txbegin_r <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      txbegin_r <= (state_nx_s == TX_START);
    end
  end

  // Sticky overflow flag; a new overflow beats a simultaneous status-read clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ovf_r <= 1'b0;
    end else if (rx_ovf_set_s) begin
      rx_ovf_r <= 1'b1;
    end else if (stat_clr_s) begin
      rx_ovf_r <= 1'b0;
    end else begin
      rx_ovf_r <= rx_ovf_r;
    end
  end

  // Flow control from RX occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uart_rts_r <= 1'b0;
    end else begin
      uart_rts_r <= (rx_count_s >= RXCW'(RTS_LEVEL));
    end
  end

  // Register read mux.
  always_comb begin
    dout = 8'hFF;
    oe   = 1'b0;
    if (rd_data_s) begin
      oe   = 1'b1;
      dout = rx_empty_s ? 8'h00 : rx_head_s;
    end else if (rd_stat_s) begin
      oe   = 1'b1;
      dout = pack_status(~rx_empty_s, tx_full_s, rx_ovf_r, tx_idle_s);
    end else begin
      oe   = 1'b0;
      dout = 8'hFF;
    end
  end

endmodule

// File: tb/tb_zxunouart_fifo.sv
// tb_zxunouart_fifo: randomized self-checking bench for zxunouart_fifo.
// Runs the core at 10 clocks per bit; the line is decoded and driven here.
module tb_zxunouart_fifo;
  import zxunouart_fifo_pkg::*;

  localparam int DIV = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] zxuno_addr = 8'h00;
  logic       zxuno_regrd = 1'b0;
  logic       zxuno_regwr = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       oe;
  logic       uart_tx;
  logic       uart_rx = 1'b1;
  logic       uart_rts;

  int total = 0;
  int bad = 0;

  logic [7:0] line_q[$];
  logic [7:0] exp_line_q[$];
  logic [7:0] rx_q[$];
  bit         ovf_m = 1'b0;

  zxunouart_fifo #(.CLK(1152000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .zxuno_addr  (zxuno_addr),
    .zxuno_regrd (zxuno_regrd),
    .zxuno_regwr (zxuno_regwr),
    .din         (din),
    .dout        (dout),
    .oe          (oe),
    .uart_tx     (uart_tx),
    .uart_rx     (uart_rx),
    .uart_rts    (uart_rts)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_stat(input bit tx_full, input bit tx_idle);
    return {rx_q.size() != 0, tx_full, ovf_m, tx_idle, 4'b0000};
  endfunction

  task automatic reg_write(input logic [7:0] a, input logic [7:0] d, input int hold);
    @(posedge clk); #1;
    zxuno_addr = a; din = d; zxuno_regwr = 1'b1;
    repeat (hold) @(posedge clk);
    #1 zxuno_regwr = 1'b0;
  endtask

  task automatic reg_read(input logic [7:0] a, input int hold, output logic [7:0] d);
    @(posedge clk); #1;
    zxuno_addr = a; zxuno_regrd = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (i == 0) d = dout;
      else check("rd_stable", dout, d);
    end
    check("rd_oe", oe, 1);
    @(posedge clk); #1;
    zxuno_regrd = 1'b0; zxuno_addr = 8'h00;
    repeat (3) @(posedge clk);
  endtask

  task automatic read_data_check(input int hold);
    logic [7:0] d;
    logic [7:0] e;
    e = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    reg_read(UARTDATA, hold, d);
    check("rx_byte", d, e);
    if (rx_q.size() != 0) void'(rx_q.pop_front());
  endtask

  task automatic send_frame(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1 uart_rx = f[i];
      repeat (DIV - 1) @(posedge clk);
    end
    repeat (6) @(posedge clk);
    if (rx_q.size() < 16) rx_q.push_back(b);
    else ovf_m = 1'b1;
  endtask

  task automatic wait_line(input int n, input int budget);
    int k;
    k = 0;
    while (line_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    check("line_count", line_q.size(), n);
  endtask

  // Line decoder: samples each bit at its centre and queues whole bytes.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (uart_tx == 1'b0) begin
        repeat (DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (DIV) @(negedge clk);
        line_q.push_back(b);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic [7:0] b;
    logic [7:0] first;
    int base;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("idle_dout", dout, 8'hFF);
    check("idle_oe", oe, 0);
    check("rts_reset", uart_rts, 0);
    check("tx_reset", uart_tx, 1);
    reg_read(UARTSTAT, 1, d);
    check("stat_reset", d, 8'h10);

    // TX burst: the first byte leaves immediately, so 16 writes leave 15 queued
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      reg_write(UARTDATA, b, 1);
      exp_line_q.push_back(b);
    end
    reg_read(UARTSTAT, 1, d);
    check("stat_15q", d, exp_stat(1'b0, 1'b0));
    b = 8'($urandom);
    reg_write(UARTDATA, b, 1);
    exp_line_q.push_back(b);
    reg_read(UARTSTAT, 1, d);
    check("stat_full", d, exp_stat(1'b1, 1'b0));
    reg_write(UARTDATA, 8'hAA, 1);   // dropped
    reg_read(UARTSTAT, 1, d);
    check("stat_full2", d, exp_stat(1'b1, 1'b0));
    wait_line(17, 17 * 12 * DIV + 200);
    repeat (30) @(posedge clk);
    check("line_no_extra", line_q.size(), exp_line_q.size());
    for (int i = 0; i < 17 && i < line_q.size(); i++) begin
      check("tx_byte", line_q[i], exp_line_q[i]);
    end
    reg_read(UARTSTAT, 1, d);
    check("stat_tx_idle", d, exp_stat(1'b0, 1'b1));

    // Held write strobe: exactly one frame
    b = 8'($urandom);
    exp_line_q.push_back(b);
    reg_write(UARTDATA, b, 4);
    wait_line(18, 300);
    repeat (15 * DIV) @(posedge clk);
    check("hold_wr_count", line_q.size(), 18);
    if (line_q.size() >= 18) check("hold_wr_byte", line_q[17], b);

    // RX fill and flow control
    for (int i = 0; i < 16; i++) begin
      send_frame(8'($urandom));
      @(negedge clk);
      check("rts_fill", uart_rts, rx_q.size() >= 12);
    end
    reg_read(UARTSTAT, 1, d);
    check("stat_rx16", d, exp_stat(1'b0, 1'b1));
    send_frame(8'($urandom));
    reg_read(UARTSTAT, 1, d);
    check("stat_ovf", d, exp_stat(1'b0, 1'b1));
    ovf_m = 1'b0;   // the read just made clears the flag
    reg_read(UARTSTAT, 1, d);
    check("stat_ovf_clr", d, exp_stat(1'b0, 1'b1));

    // Held data read, then drain with random hold lengths
    read_data_check(4);
    @(negedge clk);
    check("rts_after_hold", uart_rts, rx_q.size() >= 12);
    while (rx_q.size() != 0) begin
      read_data_check($urandom_range(1, 3));
      @(negedge clk);
      check("rts_drain", uart_rts, rx_q.size() >= 12);
    end
    read_data_check(1);   // empty read returns 00 and does not pop
    reg_read(UARTSTAT, 1, d);
    check("stat_drained", d, exp_stat(1'b0, 1'b1));

    // Reset in the middle of a TX burst
    base = line_q.size();
    first = 8'($urandom);
    reg_write(UARTDATA, first, 1);
    for (int i = 0; i < 4; i++) reg_write(UARTDATA, 8'($urandom), 1);
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    reg_read(UARTSTAT, 1, d);
    check("stat_rst_busy", d, 8'h00);
    check("rts_rst_mid", uart_rts, 0);
    wait_line(base + 1, 300);
    if (line_q.size() > base) check("inflight_byte", line_q[base], first);
    repeat (300) @(posedge clk);
    check("rst_no_extra", line_q.size(), base + 1);
    reg_read(UARTSTAT, 1, d);
    check("stat_rst_idle", d, 8'h10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
